memory_stage_lsu: RTL and testbench

Parametrised successor to the single-cycle memory stage. It adds sub-word loads and stores (byte, halfword, word selected by funct3) with byte enables and sign or zero extension. It also adds a synchronous data memory with configurable read latency, a load stall handshake toward the hazard unit, misalignment detection, and a registered MEM/WB boundary. It sits between the EX/MEM register and the writeback stage.

---
 rtl/memory_stage_lsu.sv | 271 +++++++++++++++++++++++++++
 tb/tb_memory_stage_lsu.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/memory_stage_lsu.sv
// Memory stage with sub-word loads/stores, byte-lane data memory with configurable
// read latency, load stall handshake and a registered MEM/WB boundary.
module memory_stage_lsu #(
  parameter int XLEN         = 32,
  parameter int DEPTH_WORDS  = 1024,
  parameter int READ_LATENCY = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            valid_m,
  input  logic [XLEN-1:0] execute_out_m_in,
  input  logic [XLEN-1:0] reg_readdata2_m,
  input  logic [2:0]      funct3_m,
  input  logic            dmem_read_en_m,
  input  logic            dmem_write_en_m,
  input  logic [4:0]      reg_write_addr_m_in,
  input  logic            reg_write_en_m_in,
  input  logic            reg_writedata_sel_m_in,
  output logic            stall_m,
  output logic            valid_w,
  output logic [XLEN-1:0] dmem_readdata_w,
  output logic [XLEN-1:0] execute_out_w,
  output logic [4:0]      reg_write_addr_w,
  output logic            reg_write_en_w,
  output logic            reg_writedata_sel_w,
  output logic            misaligned_exc_w
);

  localparam int         IDXW = $clog2(DEPTH_WORDS);
  localparam logic [2:0] LAT  = 3'(READ_LATENCY);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t state_q, state_d;
  logic [2:0] cnt_q, cnt_d;

  // Load context captured at acceptance so completion does not depend on held inputs
  logic [1:0]      ld_off_q, ld_off_d;
  logic [2:0]      ld_funct3_q, ld_funct3_d;
  logic [4:0]      ld_rd_q, ld_rd_d;
  logic            ld_we_q, ld_we_d;
  logic            ld_sel_q, ld_sel_d;
  logic [XLEN-1:0] ld_exec_q, ld_exec_d;

  logic            valid_w_q, valid_w_d;
  logic [XLEN-1:0] readdata_w_q, readdata_w_d;
  logic [XLEN-1:0] exec_w_q, exec_w_d;
  logic [4:0]      rd_w_q, rd_w_d;
  logic            we_w_q, we_w_d;
  logic            sel_w_q, sel_w_d;
  logic            mis_w_q, mis_w_d;

  logic [1:0]      off;
  logic            is_load, is_store, is_mem;
  logic            ld_legal, st_legal, op_legal, mis_size;
  logic            ld_go, st_go, mis_hit, illegal_hit;
  logic            stall_c, rd_en, wr_en;
  logic [3:0]      be;
  logic [XLEN-1:0] wdata;
  logic [XLEN-1:0] rd_word;
  logic [IDXW-1:0] word_idx;
  logic [7:0]      ld_byte;
  logic [15:0]     ld_half;
  logic [XLEN-1:0] ld_ext;

  assign off      = execute_out_m_in[1:0];
  assign word_idx = execute_out_m_in[IDXW+1:2];
  assign is_store = dmem_write_en_m;
  assign is_load  = dmem_read_en_m & ~dmem_write_en_m;
  assign is_mem   = is_load | is_store;

  always_comb begin
    ld_legal = 1'b0;
    case (funct3_m)
      3'b000, 3'b001, 3'b010, 3'b100, 3'b101: ld_legal = 1'b1;
      default:                                ld_legal = 1'b0;
    endcase
  end

  assign st_legal = ~funct3_m[2] & (funct3_m[1:0] != 2'b11);
  assign op_legal = is_store ? st_legal : ld_legal;

  always_comb begin
    mis_size = 1'b0;
    case (funct3_m[1:0])
      2'b01:   mis_size = off[0];
      2'b10:   mis_size = (off != 2'b00);
      default: mis_size = 1'b0;
    endcase
  end

  assign ld_go       = valid_m & is_load  & op_legal & ~mis_size;
  assign st_go       = valid_m & is_store & op_legal & ~mis_size;
  assign mis_hit     = valid_m & is_mem & op_legal & mis_size;
  assign illegal_hit = valid_m & is_mem & ~op_legal;

  assign rd_en = rst_n & (state_q == S_IDLE) & ld_go;
  assign wr_en = rst_n & (state_q == S_IDLE) & st_go;

  always_comb begin
    be    = 4'b0000;
    wdata = reg_readdata2_m;
    case (funct3_m[1:0])
      2'b00: begin
        be    = 4'b0001 << off;
        wdata = {4{reg_readdata2_m[7:0]}};
      end
      2'b01: begin
        be    = off[1] ? 4'b1100 : 4'b0011;
        wdata = {2{reg_readdata2_m[15:0]}};
      end
      default: begin
        be    = 4'b1111;
        wdata = reg_readdata2_m;
      end
    endcase
  end

  // One byte-wide RAM per lane so byte enables map onto independent write ports
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] mem_lane [DEPTH_WORDS];
      logic [7:0] rd_byte_q;

      always_ff @(posedge clk) begin
        if (wr_en && be[gi]) begin
          mem_lane[word_idx] <= wdata[8*gi +: 8];
        end
        if (rd_en) begin
          rd_byte_q <= mem_lane[word_idx];
        end
      end

      assign rd_word[8*gi +: 8] = rd_byte_q;
    end
  endgenerate

  always_comb begin
    ld_byte = rd_word[7:0];
    case (ld_off_q)
      2'b00:   ld_byte = rd_word[7:0];
      2'b01:   ld_byte = rd_word[15:8];
      2'b10:   ld_byte = rd_word[23:16];
      default: ld_byte = rd_word[31:24];
    endcase
    ld_half = ld_off_q[1] ? rd_word[31:16] : rd_word[15:0];
    ld_ext  = rd_word;
    case (ld_funct3_q)
      3'b000:  ld_ext = {{(XLEN-8){ld_byte[7]}}, ld_byte};
      3'b001:  ld_ext = {{(XLEN-16){ld_half[15]}}, ld_half};
      3'b100:  ld_ext = {{(XLEN-8){1'b0}}, ld_byte};
      3'b101:  ld_ext = {{(XLEN-16){1'b0}}, ld_half};
      default: ld_ext = rd_word;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    ld_off_d     = ld_off_q;
    ld_funct3_d  = ld_funct3_q;
    ld_rd_d      = ld_rd_q;
    ld_we_d      = ld_we_q;
    ld_sel_d     = ld_sel_q;
    ld_exec_d    = ld_exec_q;
    valid_w_d    = valid_w_q;
    readdata_w_d = readdata_w_q;
    exec_w_d     = exec_w_q;
    rd_w_d       = rd_w_q;
    we_w_d       = we_w_q;
    sel_w_d      = sel_w_q;
    mis_w_d      = mis_w_q;
    stall_c      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (ld_go) begin
          state_d     = S_WAIT;
          cnt_d       = 3'd1;
          ld_off_d    = off;
          ld_funct3_d = funct3_m;
          ld_rd_d     = reg_write_addr_m_in;
          ld_we_d     = reg_write_en_m_in;
          ld_sel_d    = reg_writedata_sel_m_in;
          ld_exec_d   = execute_out_m_in;
          stall_c     = 1'b1;
          valid_w_d   = 1'b0;
          we_w_d      = 1'b0;
          mis_w_d     = 1'b0;
        end else begin
          valid_w_d = valid_m;
          exec_w_d  = execute_out_m_in;
          rd_w_d    = reg_write_addr_m_in;
          sel_w_d   = reg_writedata_sel_m_in;
          we_w_d    = valid_m & reg_write_en_m_in & ~mis_hit & ~illegal_hit;
          mis_w_d   = mis_hit;
        end
      end
      S_WAIT: begin
        if (cnt_q == LAT) begin
          state_d      = S_IDLE;
          cnt_d        = 3'd0;
          valid_w_d    = 1'b1;
          readdata_w_d = ld_ext;
          exec_w_d     = ld_exec_q;
          rd_w_d       = ld_rd_q;
          we_w_d       = ld_we_q;
          sel_w_d      = ld_sel_q;
          mis_w_d      = 1'b0;
        end else begin
          cnt_d     = cnt_q + 3'd1;
          stall_c   = 1'b1;
          valid_w_d = 1'b0;
          we_w_d    = 1'b0;
          mis_w_d   = 1'b0;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = 3'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      cnt_q        <= 3'd0;
      ld_off_q     <= 2'd0;
      ld_funct3_q  <= 3'd0;
      ld_rd_q      <= 5'd0;
      ld_we_q      <= 1'b0;
      ld_sel_q     <= 1'b0;
      ld_exec_q    <= '0;
      valid_w_q    <= 1'b0;
      readdata_w_q <= '0;
      exec_w_q     <= '0;
      rd_w_q       <= 5'd0;
      we_w_q       <= 1'b0;
      sel_w_q      <= 1'b0;
      mis_w_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      ld_off_q     <= ld_off_d;
      ld_funct3_q  <= ld_funct3_d;
      ld_rd_q      <= ld_rd_d;
      ld_we_q      <= ld_we_d;
      ld_sel_q     <= ld_sel_d;
      ld_exec_q    <= ld_exec_d;
      valid_w_q    <= valid_w_d;
      readdata_w_q <= readdata_w_d;
      exec_w_q     <= exec_w_d;
      rd_w_q       <= rd_w_d;
      we_w_q       <= we_w_d;
      sel_w_q      <= sel_w_d;
      mis_w_q      <= mis_w_d;
    end
  end

  assign stall_m             = rst_n & stall_c;
  assign valid_w             = valid_w_q;
  assign dmem_readdata_w     = readdata_w_q;
  assign execute_out_w       = exec_w_q;
  assign reg_write_addr_w    = rd_w_q;
  assign reg_write_en_w      = we_w_q;
  assign reg_writedata_sel_w = sel_w_q;
  assign misaligned_exc_w    = mis_w_q;

endmodule

// File: tb/tb_memory_stage_lsu.sv
// Directed bench for memory_stage_lsu (READ_LATENCY=3, DEPTH_WORDS=1024) with
// hand-computed expected values for sub-word access, stalls, faults and reset abort.
module tb_memory_stage_lsu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid_m;
  logic [31:0] execute_out_m_in;
  logic [31:0] reg_readdata2_m;
  logic [2:0]  funct3_m;
  logic        dmem_read_en_m;
  logic        dmem_write_en_m;
  logic [4:0]  reg_write_addr_m_in;
  logic        reg_write_en_m_in;
  logic        reg_writedata_sel_m_in;
  logic        stall_m;
  logic        valid_w;
  logic [31:0] dmem_readdata_w;
  logic [31:0] execute_out_w;
  logic [4:0]  reg_write_addr_w;
  logic        reg_write_en_w;
  logic        reg_writedata_sel_w;
  logic        misaligned_exc_w;

  int total = 0;
  int bad   = 0;
  int n;

  always #5 clk = ~clk;

  memory_stage_lsu #(
    .XLEN(32),
    .DEPTH_WORDS(1024),
    .READ_LATENCY(3)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .valid_m(valid_m),
    .execute_out_m_in(execute_out_m_in),
    .reg_readdata2_m(reg_readdata2_m),
    .funct3_m(funct3_m),
    .dmem_read_en_m(dmem_read_en_m),
    .dmem_write_en_m(dmem_write_en_m),
    .reg_write_addr_m_in(reg_write_addr_m_in),
    .reg_write_en_m_in(reg_write_en_m_in),
    .reg_writedata_sel_m_in(reg_writedata_sel_m_in),
    .stall_m(stall_m),
    .valid_w(valid_w),
    .dmem_readdata_w(dmem_readdata_w),
    .execute_out_w(execute_out_w),
    .reg_write_addr_w(reg_write_addr_w),
    .reg_write_en_w(reg_write_en_w),
    .reg_writedata_sel_w(reg_writedata_sel_w),
    .misaligned_exc_w(misaligned_exc_w)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic idle_inputs();
    valid_m                = 1'b0;
    dmem_read_en_m         = 1'b0;
    dmem_write_en_m        = 1'b0;
    reg_write_en_m_in      = 1'b0;
    reg_writedata_sel_m_in = 1'b0;
  endtask

  // Presents one instruction shortly after an edge, holds it through any stall,
  // and returns with the WB result visible; nstall counts stalled cycles.
  task automatic issue(input string name, input logic v, input logic rd, input logic wr,
                       input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] data,
                       input logic [4:0] rdst, input logic we, output int nstall);
    valid_m                = v;
    dmem_read_en_m         = rd;
    dmem_write_en_m        = wr;
    funct3_m               = f3;
    execute_out_m_in       = addr;
    reg_readdata2_m        = data;
    reg_write_addr_m_in    = rdst;
    reg_write_en_m_in      = we;
    reg_writedata_sel_m_in = rd;
    #1;
    nstall = 0;
    while (stall_m && nstall < 20) begin
      @(posedge clk);
      #1;
      nstall++;
      check_eq({name, "_bubble_valid"}, 32'(valid_w), 32'd0);
      check_eq({name, "_bubble_we"}, 32'(reg_write_en_w), 32'd0);
    end
    if (nstall >= 20) check_eq({name, "_stall_timeout"}, 32'(nstall), 32'd0);
    @(posedge clk);
    #1;
    idle_inputs();
    $display("op %s f3=%0d addr=%h data=%h stalls=%0d -> valid_w=%b rdata=%h mis=%b we=%b",
             name, f3, addr, data, nstall, valid_w, dmem_readdata_w, misaligned_exc_w,
             reg_write_en_w);
  endtask

  initial begin
    rst_n               = 1'b0;
    execute_out_m_in    = '0;
    reg_readdata2_m     = '0;
    funct3_m            = 3'd0;
    reg_write_addr_m_in = 5'd0;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_valid", 32'(valid_w), 32'd0);
    check_eq("rst_rdata", dmem_readdata_w, 32'd0);
    check_eq("rst_exec", execute_out_w, 32'd0);
    check_eq("rst_we", 32'(reg_write_en_w), 32'd0);
    check_eq("rst_mis", 32'(misaligned_exc_w), 32'd0);
    check_eq("rst_stall", 32'(stall_m), 32'd0);
    rst_n = 1'b1;

    // Sub-word loads from a full word
    issue("sw10", 1, 0, 1, 3'b010, 32'h10, 32'hDEADBEEF, 5'd0, 0, n);
    check_eq("sw10_stall", 32'(n), 32'd0);
    check_eq("sw10_valid", 32'(valid_w), 32'd1);
    check_eq("sw10_mis", 32'(misaligned_exc_w), 32'd0);
    issue("lb13", 1, 1, 0, 3'b000, 32'h13, 32'h0, 5'd5, 1, n);
    check_eq("lb13_data", dmem_readdata_w, 32'hFFFFFFDE);
    check_eq("lb13_stall", 32'(n), 32'd3);
    check_eq("lb13_rd", 32'(reg_write_addr_w), 32'd5);
    check_eq("lb13_we", 32'(reg_write_en_w), 32'd1);
    check_eq("lb13_sel", 32'(reg_writedata_sel_w), 32'd1);
    issue("lbu13", 1, 1, 0, 3'b100, 32'h13, 32'h0, 5'd6, 1, n);
    check_eq("lbu13_data", dmem_readdata_w, 32'h000000DE);
    issue("lh10", 1, 1, 0, 3'b001, 32'h10, 32'h0, 5'd6, 1, n);
    check_eq("lh10_data", dmem_readdata_w, 32'hFFFFBEEF);

    // Byte/halfword stores preserve the other lanes
    issue("sw20", 1, 0, 1, 3'b010, 32'h20, 32'h11223344, 5'd0, 0, n);
    issue("sb21", 1, 0, 1, 3'b000, 32'h21, 32'h000000AA, 5'd0, 0, n);
    issue("lw20a", 1, 1, 0, 3'b010, 32'h20, 32'h0, 5'd8, 1, n);
    check_eq("lw20a_data", dmem_readdata_w, 32'h1122AA44);
    issue("sh22", 1, 0, 1, 3'b001, 32'h22, 32'h00005566, 5'd0, 0, n);
    issue("lw20b", 1, 1, 0, 3'b010, 32'h20, 32'h0, 5'd9, 1, n);
    check_eq("lw20b_data", dmem_readdata_w, 32'h5566AA44);
    check_eq("lw20b_stall", 32'(n), 32'd3);
    check_eq("lw20b_valid", 32'(valid_w), 32'd1);
    issue("lb21", 1, 1, 0, 3'b000, 32'h21, 32'h0, 5'd9, 1, n);
    check_eq("lb21_data", dmem_readdata_w, 32'hFFFFFFAA);
    issue("lhu22", 1, 1, 0, 3'b101, 32'h22, 32'h0, 5'd9, 1, n);
    check_eq("lhu22_data", dmem_readdata_w, 32'h00005566);

    // Misaligned accesses: no stall, no memory effect, read data held
    issue("lw22", 1, 1, 0, 3'b010, 32'h22, 32'h0, 5'd10, 1, n);
    check_eq("lw22_stall", 32'(n), 32'd0);
    check_eq("lw22_valid", 32'(valid_w), 32'd1);
    check_eq("lw22_mis", 32'(misaligned_exc_w), 32'd1);
    check_eq("lw22_we", 32'(reg_write_en_w), 32'd0);
    check_eq("lw22_hold", dmem_readdata_w, 32'h00005566);
    issue("sw22", 1, 0, 1, 3'b010, 32'h22, 32'h00000000, 5'd0, 0, n);
    check_eq("sw22_mis", 32'(misaligned_exc_w), 32'd1);
    issue("lh21", 1, 1, 0, 3'b001, 32'h21, 32'h0, 5'd10, 1, n);
    check_eq("lh21_mis", 32'(misaligned_exc_w), 32'd1);
    issue("lw20c", 1, 1, 0, 3'b010, 32'h20, 32'h0, 5'd10, 1, n);
    check_eq("lw20c_data", dmem_readdata_w, 32'h5566AA44);

    // Illegal funct3
    issue("ld011", 1, 1, 0, 3'b011, 32'h20, 32'h0, 5'd11, 1, n);
    check_eq("ld011_stall", 32'(n), 32'd0);
    check_eq("ld011_valid", 32'(valid_w), 32'd1);
    check_eq("ld011_mis", 32'(misaligned_exc_w), 32'd0);
    check_eq("ld011_we", 32'(reg_write_en_w), 32'd0);
    issue("st011", 1, 0, 1, 3'b011, 32'h20, 32'hFFFFFFFF, 5'd0, 0, n);
    issue("lw20d", 1, 1, 0, 3'b010, 32'h20, 32'h0, 5'd11, 1, n);
    check_eq("lw20d_data", dmem_readdata_w, 32'h5566AA44);

    // Read and write both asserted behaves as a store
    issue("rw30", 1, 1, 1, 3'b010, 32'h30, 32'hCAFEF00D, 5'd0, 0, n);
    check_eq("rw30_stall", 32'(n), 32'd0);
    issue("lw30", 1, 1, 0, 3'b010, 32'h30, 32'h0, 5'd12, 1, n);
    check_eq("lw30_data", dmem_readdata_w, 32'hCAFEF00D);

    // ALU passthrough and an invalid slot
    issue("alu", 1, 0, 0, 3'b000, 32'h1234ABCD, 32'h0, 5'd7, 1, n);
    check_eq("alu_exec", execute_out_w, 32'h1234ABCD);
    check_eq("alu_rd", 32'(reg_write_addr_w), 32'd7);
    check_eq("alu_we", 32'(reg_write_en_w), 32'd1);
    check_eq("alu_sel", 32'(reg_writedata_sel_w), 32'd0);
    check_eq("alu_hold", dmem_readdata_w, 32'hCAFEF00D);
    issue("nop", 0, 0, 0, 3'b000, 32'h55, 32'h0, 5'd7, 1, n);
    check_eq("nop_valid", 32'(valid_w), 32'd0);
    check_eq("nop_we", 32'(reg_write_en_w), 32'd0);

    // Address wrap modulo DEPTH_WORDS*4
    issue("sw1004", 1, 0, 1, 3'b010, 32'h1004, 32'h12345678, 5'd0, 0, n);
    issue("lw0004", 1, 1, 0, 3'b010, 32'h0004, 32'h0, 5'd13, 1, n);
    check_eq("wrap_data", dmem_readdata_w, 32'h12345678);

    // Reset in the second WAIT cycle aborts the load
    valid_m                = 1'b1;
    dmem_read_en_m         = 1'b1;
    funct3_m               = 3'b010;
    execute_out_m_in       = 32'h4;
    reg_write_addr_m_in    = 5'd14;
    reg_write_en_m_in      = 1'b1;
    reg_writedata_sel_m_in = 1'b1;
    #1;
    check_eq("abort_accept_stall", 32'(stall_m), 32'd1);
    @(posedge clk);
    #1;
    check_eq("abort_wait1_stall", 32'(stall_m), 32'd1);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    idle_inputs();
    @(posedge clk);
    #1;
    $display("op abort_reset -> stall=%b valid_w=%b rdata=%h", stall_m, valid_w, dmem_readdata_w);
    check_eq("abort_stall", 32'(stall_m), 32'd0);
    check_eq("abort_valid", 32'(valid_w), 32'd0);
    check_eq("abort_rdata", dmem_readdata_w, 32'd0);
    check_eq("abort_exec", execute_out_w, 32'd0);
    check_eq("abort_rd", 32'(reg_write_addr_w), 32'd0);
    check_eq("abort_we", 32'(reg_write_en_w), 32'd0);
    check_eq("abort_sel", 32'(reg_writedata_sel_w), 32'd0);
    check_eq("abort_mis", 32'(misaligned_exc_w), 32'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      check_eq("abort_no_result", 32'(valid_w), 32'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
